// File: rtl/oam_dma_controller_pkg.sv
// Shared PPU-side types and constants for the OAM DMA controller.
package oam_dma_controller_pkg;

    typedef enum logic [1:0] {MODE_0, MODE_1, MODE_2, MODE_3} ppu_mode_t;

    typedef enum logic [1:0] {DMA_IDLE, DMA_DELAY, DMA_XFER} dma_state_t;

    localparam logic [15:0] OAM_DMA_REG_ADDR = 16'hFF46;
    localparam int unsigned OAM_BYTES        = 160;
    localparam int unsigned CYCLES_PER_BYTE  = 4;
    localparam int unsigned START_DELAY      = 4;

    // Source pages E0..FF alias the echo region and are fetched from C0..DF.
    function automatic logic [7:0] dma_src_page(input logic [7:0] dma_reg);
        return (dma_reg >= 8'hE0) ? {dma_reg[7:6], 1'b0, dma_reg[4:0]} : dma_reg;
    endfunction

endpackage

// File: rtl/oam_dma_controller_if.sv
// Register bus, source read port, OAM write port and MMU blocking signals of the OAM DMA.
interface oam_dma_controller_if;
    import oam_dma_controller_pkg::*;

    logic        reg_write_en;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    ppu_mode_t   ppu_mode;
    logic        src_req;
    logic [15:0] src_addr;
    logic [7:0]  src_rdata;
    logic        cpu_oam_we;
    logic [7:0]  cpu_oam_addr;
    logic [7:0]  cpu_oam_wdata;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        dma_active;
    logic        cpu_oam_block;
    logic        cpu_bus_block;

    modport master (
        input  reg_write_en, reg_addr, reg_wdata, ppu_mode, src_rdata,
               cpu_oam_we, cpu_oam_addr, cpu_oam_wdata,
        output reg_rdata, src_req, src_addr, oam_we, oam_addr, oam_wdata,
               dma_active, cpu_oam_block, cpu_bus_block
    );

    modport slave (
        output reg_write_en, reg_addr, reg_wdata, ppu_mode, src_rdata,
               cpu_oam_we, cpu_oam_addr, cpu_oam_wdata,
        input  reg_rdata, src_req, src_addr, oam_we, oam_addr, oam_wdata,
               dma_active, cpu_oam_block, cpu_bus_block
    );

endinterface

// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: FF46-triggered 160-byte copy into OAM, one byte per M-cycle, plus
// arbitration of the OAM write port and the CPU access-blocking signals for the MMU.
module oam_dma_controller (
    input logic                  clk,
    input logic                  reset,
    oam_dma_controller_if.master bus
);
    import oam_dma_controller_pkg::*;

    localparam int unsigned PHASE_W = $clog2(CYCLES_PER_BYTE);
    localparam int unsigned DELAY_W = $clog2(START_DELAY);

    localparam logic [7:0]         IDX_LAST   = 8'(OAM_BYTES - 1);
    localparam logic [PHASE_W-1:0] PH_REQ     = '0;
    localparam logic [PHASE_W-1:0] PH_LATCH   = PHASE_W'(1);
    localparam logic [PHASE_W-1:0] PH_WRITE   = PHASE_W'(2);
    localparam logic [PHASE_W-1:0] PH_LAST    = PHASE_W'(CYCLES_PER_BYTE - 1);
    localparam logic [DELAY_W-1:0] DELAY_LAST = DELAY_W'(START_DELAY - 1);

    dma_state_t         state_q;
    logic [7:0]         dma_reg_q;
    logic [7:0]         idx_q;
    logic [7:0]         data_q;
    logic [PHASE_W-1:0] phase_q;
    logic [DELAY_W-1:0] delay_q;
    logic               start;
    logic               xfer;

    assign start = bus.reg_write_en && (bus.reg_addr == OAM_DMA_REG_ADDR);
    assign xfer  = (state_q == DMA_XFER);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= DMA_IDLE;
            dma_reg_q <= 8'hFF;
            idx_q     <= '0;
            data_q    <= '0;
            phase_q   <= '0;
            delay_q   <= '0;
        end else begin
            unique case (state_q)
                DMA_IDLE: ;
                DMA_DELAY: begin
                    if (delay_q == DELAY_LAST) begin
                        state_q <= DMA_XFER;
                        phase_q <= PH_REQ;
                    end else begin
                        delay_q <= delay_q + DELAY_W'(1);
                    end
                end
                DMA_XFER: begin
                    if (phase_q == PH_LATCH) begin
                        data_q <= bus.src_rdata;
                    end
                    if (phase_q == PH_LAST) begin
                        phase_q <= PH_REQ;
                        if (idx_q == IDX_LAST) begin
                            state_q <= DMA_IDLE;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 8'd1;
                        end
                    end else begin
                        phase_q <= phase_q + PHASE_W'(1);
                    end
                end
                default: state_q <= DMA_IDLE;
            endcase
            // A new FF46 write overrides whatever the sequencer chose this cycle.
            if (start) begin
                state_q   <= DMA_DELAY;
                dma_reg_q <= bus.reg_wdata;
                idx_q     <= '0;
                phase_q   <= PH_REQ;
                delay_q   <= '0;
            end
        end
    end

    always_comb begin
        bus.reg_rdata     = (bus.reg_addr == OAM_DMA_REG_ADDR) ? dma_reg_q : 8'h00;
        bus.dma_active    = (state_q != DMA_IDLE);
        bus.cpu_bus_block = bus.dma_active;
        bus.cpu_oam_block = bus.dma_active || (bus.ppu_mode == MODE_2) ||
                            (bus.ppu_mode == MODE_3);
        bus.src_req       = xfer && (phase_q == PH_REQ);
        bus.src_addr      = bus.src_req ? {dma_src_page(dma_reg_q), idx_q} : 16'h0000;

        bus.oam_we    = 1'b0;
        bus.oam_addr  = 8'h00;
        bus.oam_wdata = 8'h00;
        if (xfer && (phase_q == PH_WRITE)) begin
            bus.oam_we    = 1'b1;
            bus.oam_addr  = idx_q;
            bus.oam_wdata = data_q;
        end else if (bus.cpu_oam_we && !bus.cpu_oam_block) begin
            bus.oam_we    = 1'b1;
            bus.oam_addr  = bus.cpu_oam_addr;
            bus.oam_wdata = bus.cpu_oam_wdata;
        end
    end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller: combinational vector table plus transfer,
// restart, reset and end-of-transfer corner sequences against a byte-level OAM model.
module tb_oam_dma_controller;
    import oam_dma_controller_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    oam_dma_controller_if bus();

    oam_dma_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] addr;
        ppu_mode_t   mode;
        logic        we;
        logic [7:0]  ca;
        logic [7:0]  cd;
        logic [7:0]  e_rdata;
        logic        e_we;
        logic [7:0]  e_addr;
        logic [7:0]  e_data;
        logic        e_block;
    } vec_t;

    vec_t vecs [6];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] oam_mem [256];
    logic [7:0] exp_page    = 8'h00;
    logic [7:0] exp_idx     = 8'h00;
    logic [7:0] next_page   = 8'h00;
    int         src_err     = 0;
    int         we_since_w  = 0;
    int         we_total    = 0;
    int         act_since_w = 0;
    int         act_total   = 0;
    int         act_fall    = 0;
    int         cyc_since_w = 0;
    int         first_src   = 0;
    logic       first_seen  = 1'b1;
    logic       act_prev    = 1'b0;

    // Source memory: data is a function of the full address so each page is distinguishable.
    always @(posedge clk) begin
        bus.src_rdata <= bus.src_req ?
                         (bus.src_addr[7:0] ^ bus.src_addr[15:8] ^ 8'h5A) : 8'h00;
    end

    always @(negedge clk) begin
        if (bus.src_req) begin
            if (bus.src_addr != {exp_page, exp_idx}) src_err <= src_err + 1;
            exp_idx <= exp_idx + 8'd1;
            if (!first_seen) begin
                first_src  <= cyc_since_w + 1;
                first_seen <= 1'b1;
            end
        end
        if (bus.oam_we) begin
            oam_mem[bus.oam_addr] <= bus.oam_wdata;
            we_since_w <= we_since_w + 1;
            we_total   <= we_total + 1;
        end
        if (bus.dma_active) act_total <= act_total + 1;
        if (act_prev && !bus.dma_active) act_fall <= act_fall + 1;
        act_prev <= bus.dma_active;
        if (bus.reg_write_en && bus.reg_addr == 16'hFF46) begin
            exp_page    <= next_page;
            exp_idx     <= 8'h00;
            we_since_w  <= 0;
            act_since_w <= 0;
            cyc_since_w <= 0;
            first_seen  <= 1'b0;
        end else begin
            if (bus.dma_active) act_since_w <= act_since_w + 1;
            cyc_since_w <= cyc_since_w + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    task automatic idle_inputs();
        bus.reg_write_en  = 1'b0;
        bus.reg_addr      = 16'hFF46;
        bus.reg_wdata     = 8'h00;
        bus.ppu_mode      = MODE_0;
        bus.cpu_oam_we    = 1'b0;
        bus.cpu_oam_addr  = 8'h00;
        bus.cpu_oam_wdata = 8'h00;
    endtask

    // Call right after a posedge; the write occupies the following cycle.
    task automatic write_ff46(input logic [7:0] val, input logic [7:0] src_page);
        #1;
        next_page        = src_page;
        bus.reg_write_en = 1'b1;
        bus.reg_addr     = 16'hFF46;
        bus.reg_wdata    = val;
        @(posedge clk);
        #1;
        bus.reg_write_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.dma_active && n < budget);
        check({name, "_done"}, 32'(bus.dma_active), 32'd0);
        @(posedge clk);
    endtask

    task automatic wait_we(input string name, input int target, input int budget);
        int k = 0;
        while (we_since_w < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        check({name, "_reached"}, 32'(we_since_w >= target), 32'd1);
    endtask

    task automatic check_data(input string name, input int count, input logic [7:0] key);
        int bad = 0;
        for (int i = 0; i < count; i++) begin
            if (oam_mem[i] !== (8'(i) ^ key)) bad++;
        end
        check({name, "_bad_bytes"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int base_err;
        int base_fall;
        int base_total;
        int base_we;

        vecs[0] = '{16'hFF46, MODE_0, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{16'hFF45, MODE_0, 1'b1, 8'h10, 8'h33, 8'h00, 1'b1, 8'h10, 8'h33, 1'b0};
        vecs[2] = '{16'hFF46, MODE_1, 1'b1, 8'h9F, 8'hA5, 8'hFF, 1'b1, 8'h9F, 8'hA5, 1'b0};
        vecs[3] = '{16'hFF46, MODE_2, 1'b1, 8'h40, 8'hEE, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[4] = '{16'h0000, MODE_3, 1'b1, 8'h41, 8'hEF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[5] = '{16'hFF47, MODE_0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dma_active", 32'(bus.dma_active), 32'd0);
        check("rst_rdata", 32'(bus.reg_rdata), 32'hFF);
        check("rst_src_req", 32'(bus.src_req), 32'd0);
        check("rst_oam_we", 32'(bus.oam_we), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            bus.reg_addr      = vecs[i].addr;
            bus.ppu_mode      = vecs[i].mode;
            bus.cpu_oam_we    = vecs[i].we;
            bus.cpu_oam_addr  = vecs[i].ca;
            bus.cpu_oam_wdata = vecs[i].cd;
            @(negedge clk);
            check($sformatf("vec%0d_rdata", i), 32'(bus.reg_rdata), 32'(vecs[i].e_rdata));
            check($sformatf("vec%0d_oam_we", i), 32'(bus.oam_we), 32'(vecs[i].e_we));
            check($sformatf("vec%0d_oam_addr", i), 32'(bus.oam_addr), 32'(vecs[i].e_addr));
            check($sformatf("vec%0d_oam_wdata", i), 32'(bus.oam_wdata), 32'(vecs[i].e_data));
            check($sformatf("vec%0d_oam_block", i), 32'(bus.cpu_oam_block),
                  32'(vecs[i].e_block));
            check($sformatf("vec%0d_bus_block", i), 32'(bus.cpu_bus_block), 32'd0);
        end
        @(posedge clk);
        #1 idle_inputs();

        // Basic transfer from page C1.
        @(posedge clk);
        base_err = src_err;
        write_ff46(8'hC1, 8'hC1);
        wait_idle("c1", 800);
        check("c1_first_src_cycle", 32'(first_src), 32'd5);
        check("c1_active_cycles", 32'(act_since_w), 32'd644);
        check("c1_oam_writes", 32'(we_since_w), 32'd160);
        check("c1_src_addr_errs", 32'(src_err - base_err), 32'd0);
        check_data("c1", 160, 8'h9B);

        // Echo page E3 fetches from C3; CPU write in the start delay is dropped.
        @(posedge clk);
        base_err = src_err;
        write_ff46(8'hE3, 8'hC3);
        bus.cpu_oam_we    = 1'b1;
        bus.cpu_oam_addr  = 8'h20;
        bus.cpu_oam_wdata = 8'h77;
        @(negedge clk);
        check("e3_cpu_we_blocked", 32'(bus.oam_we), 32'd0);
        check("e3_oam_block", 32'(bus.cpu_oam_block), 32'd1);
        check("e3_bus_block", 32'(bus.cpu_bus_block), 32'd1);
        check("e3_readback", 32'(bus.reg_rdata), 32'hE3);
        @(posedge clk);
        #1 bus.cpu_oam_we = 1'b0;
        wait_idle("e3", 800);
        check("e3_oam_writes", 32'(we_since_w), 32'd160);
        check("e3_src_addr_errs", 32'(src_err - base_err), 32'd0);
        check_data("e3", 160, 8'h99);

        // Restart mid-transfer with page D0.
        @(posedge clk);
        base_err  = src_err;
        base_fall = act_fall;
        write_ff46(8'hC1, 8'hC1);
        wait_we("rs_c1", 50, 400);
        check_data("rs_c1_first50", 50, 8'h9B);
        write_ff46(8'hD0, 8'hD0);
        wait_idle("rs", 800);
        check("rs_active_falls", 32'(act_fall - base_fall), 32'd1);
        check("rs_active_cycles", 32'(act_since_w), 32'd644);
        check("rs_oam_writes", 32'(we_since_w), 32'd160);
        check("rs_src_addr_errs", 32'(src_err - base_err), 32'd0);
        check_data("rs_d0", 160, 8'h8A);

        // Reset at byte 80, then a fresh transfer from C2.
        @(posedge clk);
        write_ff46(8'hC1, 8'hC1);
        wait_we("mr_c1", 80, 700);
        #1 reset = 1'b1;
        base_we = we_total;
        @(negedge clk);
        check("mr_dma_active", 32'(bus.dma_active), 32'd0);
        check("mr_oam_we", 32'(bus.oam_we), 32'd0);
        check("mr_src_req", 32'(bus.src_req), 32'd0);
        check("mr_rdata", 32'(bus.reg_rdata), 32'hFF);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        check("mr_no_oam_we", 32'(we_total - base_we), 32'd0);
        base_err = src_err;
        write_ff46(8'hC2, 8'hC2);
        wait_idle("mr", 800);
        check("mr_active_cycles", 32'(act_since_w), 32'd644);
        check("mr_oam_writes", 32'(we_since_w), 32'd160);
        check("mr_src_addr_errs", 32'(src_err - base_err), 32'd0);
        check_data("mr_c2", 160, 8'h98);

        // FF46 write landing on the final phase-3 cycle restarts instead of ending.
        @(posedge clk);
        base_err   = src_err;
        base_fall  = act_fall;
        base_total = act_total;
        write_ff46(8'hC1, 8'hC1);
        wait_we("end_c1", 160, 700);
        write_ff46(8'h80, 8'h80);
        @(negedge clk);
        check("end_active_after_restart", 32'(bus.dma_active), 32'd1);
        wait_idle("end", 800);
        check("end_active_falls", 32'(act_fall - base_fall), 32'd1);
        check("end_active_total", 32'(act_total - base_total), 32'd1288);
        check("end_active_cycles", 32'(act_since_w), 32'd644);
        check("end_oam_writes", 32'(we_since_w), 32'd160);
        check("end_src_addr_errs", 32'(src_err - base_err), 32'd0);
        check_data("end_80", 160, 8'hDA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
